// File: rtl/dsp_pkg.sv
// Shared types and arithmetic helpers for the moving-average reader.
// Define MOVING_AVG_ROUND_EN for round-half-up averages instead of truncation.
package dsp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CALC = 2'd2,
        EMIT = 2'd3
    } state_t;

    // Divides a window sum by 2**lg; the caller clamps the result to the sample width.
    function automatic logic [31:0] avg_shift(input logic [31:0] sum, input int unsigned lg);
`ifdef MOVING_AVG_ROUND_EN
        logic [31:0] half;
        half = (32'd1 << lg) >> 1;
        return (sum + half) >> lg;
`else
        return sum >> lg;
`endif
    endfunction

endpackage

// File: rtl/sample_delay_line.sv
// n-deep sample history; shifting in a new sample drops the oldest one.
module sample_delay_line #(
    parameter int w = 4,
    parameter int n = 8
) (
    input  logic         clock_i,
    input  logic         rst_ni,
    input  logic         shift_en_i,
    input  logic [w-1:0] sample_i,
    output logic [w-1:0] oldest_o
);

    logic [w-1:0] hist_q [n];

    always_ff @(posedge clock_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < n; i++) begin
                hist_q[i] <= '0;
            end
        end else if (shift_en_i) begin
            hist_q[0] <= sample_i;
            for (int i = 1; i < n; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
        end
    end

    // Entry n-1 is the sample that leaves the window on the next shift.
    assign oldest_o = hist_q[n-1];

endmodule

// File: rtl/moving_avg_reader.sv
// Pops samples from the upstream FIFO and streams the sliding-window average.
// Build option: MOVING_AVG_ROUND_EN selects round-half-up out_data (see dsp_pkg).
module moving_avg_reader
    import dsp_pkg::*;
#(
    parameter int w = 4,
    parameter int n = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      fifo_empty,
    output logic                      fifo_re,
    input  logic [w-1:0]              fifo_rdata,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [w-1:0]              out_data,
    output logic [w+$clog2(n)-1:0]    out_sum,
    output state_t                    dbg_state
);

    localparam int lg = $clog2(n);
    localparam int sw = w + lg;
    localparam logic [31:0] avg_max = 32'((1 << w) - 1);

    state_t         state_q, state_d;
    logic [sw-1:0]  sum_q, sum_d;
    logic [w-1:0]   out_data_q, avg_d;
    logic [w-1:0]   oldest;
    logic [31:0]    avg_full;
    logic           shift_en;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output stream: out_data/out_sum are offered while out_valid is high and are
    // held unchanged until the cycle out_valid && out_ready, when the beat transfers.
    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        unique case (state_q)
            IDLE: if (!fifo_empty) state_d = READ;
            READ: state_d = CALC;
            CALC: begin
                shift_en = 1'b1;
                state_d  = EMIT;
            end
            EMIT: if (out_ready) state_d = fifo_empty ? IDLE : READ;
            default: state_d = IDLE;
        endcase
    end

    // The evicted sample is always part of sum_q, so the subtraction never wraps.
    always_comb begin
        sum_d    = sum_q + sw'(fifo_rdata) - sw'(oldest);
        avg_full = avg_shift(32'(sum_d), lg);
        avg_d    = (avg_full > avg_max) ? '1 : avg_full[w-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_q      <= '0;
            out_data_q <= '0;
        end else if (shift_en) begin
            sum_q      <= sum_d;
            out_data_q <= avg_d;
        end
    end

    sample_delay_line #(
        .w (w),
        .n (n)
    ) u_delay (
        .clock_i    (clock),
        .rst_ni     (reset),
        .shift_en_i (shift_en),
        .sample_i   (fifo_rdata),
        .oldest_o   (oldest)
    );

    assign fifo_re   = (state_q == READ);
    assign out_valid = (state_q == EMIT);
    assign out_data  = out_data_q;
    assign out_sum   = sum_q;
    assign dbg_state = state_q;

endmodule
